// File: rtl/fpga_wrapper.sv
// Smith-Waterman local-alignment engine with affine gaps: loads a fixed target into
// a register file, then sweeps the S x T score matrix one cell per cycle.
module fpga_wrapper #(
  parameter int                 T_LEN   = 8,
  parameter int                 S_LEN   = 8,
  parameter logic [2*T_LEN-1:0] T_SEQ   = '0,
  parameter logic [2*S_LEN-1:0] S_SEQ   = '0,
  parameter int                 SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_set_t,
  input  logic               i_start_cal,
  input  logic [3:0]         i_match,
  input  logic [3:0]         i_mismatch,
  input  logic [3:0]         i_minusAlpha,
  input  logic [3:0]         i_minusBeta,
  output logic               o_busy,
  output logic               o_valid,
  output logic [SCORE_W-1:0] o_result
);

  // Handshake: i_set_t / i_start_cal are single-cycle pulses honoured only while idle
  // with no command already captured; o_valid is a one-cycle strobe qualifying o_result.

  localparam int J_W = (T_LEN > 1) ? $clog2(T_LEN) : 1;
  localparam int I_W = (S_LEN > 1) ? $clog2(S_LEN) : 1;
  localparam logic [J_W-1:0] J_LAST = J_W'(T_LEN - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(S_LEN - 1);

  typedef logic [SCORE_W-1:0] score_t;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_e;

  function automatic score_t sub_sat(score_t a, logic [3:0] b);
    score_t bx;
    bx = score_t'(b);
    return (a > bx) ? (a - bx) : '0;
  endfunction

  function automatic score_t add_sat(score_t a, logic [3:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W + 1)'(b);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  function automatic score_t max2(score_t a, score_t b);
    return (a > b) ? a : b;
  endfunction

  state_e         state_q, state_d;
  logic           loaded_q, loaded_d;
  logic           set_q, set_d;
  logic           start_q, start_d;
  logic [1:0]     t_reg_q [T_LEN];
  logic [1:0]     t_reg_d [T_LEN];
  score_t         h_row_q [T_LEN];
  score_t         h_row_d [T_LEN];
  score_t         f_row_q [T_LEN];
  score_t         f_row_d [T_LEN];
  logic [J_W-1:0] j_q, j_d;
  logic [I_W-1:0] i_q, i_d;
  score_t         h_left_q, h_left_d;
  score_t         e_left_q, e_left_d;
  score_t         diag_q, diag_d;
  score_t         max_q, max_d;
  score_t         result_q, result_d;
  logic [3:0]     match_q, match_d;
  logic [3:0]     mis_q, mis_d;
  logic [3:0]     alpha_q, alpha_d;
  logic [3:0]     beta_q, beta_d;

  logic [1:0]     s_base;
  logic [1:0]     t_base;
  score_t         h_up;
  score_t         f_up;
  score_t         e_new;
  score_t         f_new;
  score_t         diag_sc;
  score_t         h_new;

  // One matrix cell: left neighbours come from the running pair, upper ones from the row store.
  always_comb begin
    s_base  = S_SEQ[{i_q, 1'b0} +: 2];
    t_base  = t_reg_q[j_q];
    h_up    = h_row_q[j_q];
    f_up    = f_row_q[j_q];
    e_new   = max2(sub_sat(h_left_q, alpha_q), sub_sat(e_left_q, beta_q));
    f_new   = max2(sub_sat(h_up, alpha_q), sub_sat(f_up, beta_q));
    diag_sc = (s_base == t_base) ? add_sat(diag_q, match_q) : sub_sat(diag_q, mis_q);
    h_new   = max2(max2(e_new, f_new), diag_sc);
  end

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    t_reg_d  = t_reg_q;
    h_row_d  = h_row_q;
    f_row_d  = f_row_q;
    j_d      = j_q;
    i_d      = i_q;
    h_left_d = h_left_q;
    e_left_d = e_left_q;
    diag_d   = diag_q;
    max_d    = max_q;
    result_d = result_q;
    match_d  = match_q;
    mis_d    = mis_q;
    alpha_d  = alpha_q;
    beta_d   = beta_q;

    // Capture a command pulse; set wins over start when both arrive together.
    set_d   = (state_q == IDLE) && !set_q && !start_q && i_set_t;
    start_d = (state_q == IDLE) && !set_q && !start_q && i_start_cal && !i_set_t;
    if (start_d) begin
      match_d = i_match;
      mis_d   = i_mismatch;
      alpha_d = i_minusAlpha;
      beta_d  = i_minusBeta;
    end

    unique case (state_q)
      IDLE: begin
        if (set_q) begin
          state_d = LOAD;
          j_d     = '0;
        end else if (start_q && loaded_q) begin
          state_d  = CALC;
          i_d      = '0;
          j_d      = '0;
          h_left_d = '0;
          e_left_d = '0;
          diag_d   = '0;
          max_d    = '0;
          for (int k = 0; k < T_LEN; k++) begin
            h_row_d[k] = '0;
            f_row_d[k] = '0;
          end
        end
      end
      LOAD: begin
        t_reg_d[j_q] = T_SEQ[{j_q, 1'b0} +: 2];
        if (j_q == J_LAST) begin
          j_d      = '0;
          loaded_d = 1'b1;
          state_d  = IDLE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      CALC: begin
        h_row_d[j_q] = h_new;
        f_row_d[j_q] = f_new;
        max_d        = max2(max_q, h_new);
        if (j_q == J_LAST) begin
          j_d      = '0;
          h_left_d = '0;
          e_left_d = '0;
          diag_d   = '0;
          if (i_q == I_LAST) begin
            state_d  = DONE;
            result_d = max2(max_q, h_new);
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d      = j_q + 1'b1;
          h_left_d = h_new;
          e_left_d = e_new;
          // The cell above becomes the diagonal of the next cell in this row.
          diag_d   = h_up;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      set_q    <= 1'b0;
      start_q  <= 1'b0;
      t_reg_q  <= '{default: '0};
      h_row_q  <= '{default: '0};
      f_row_q  <= '{default: '0};
      j_q      <= '0;
      i_q      <= '0;
      h_left_q <= '0;
      e_left_q <= '0;
      diag_q   <= '0;
      max_q    <= '0;
      result_q <= '0;
      match_q  <= '0;
      mis_q    <= '0;
      alpha_q  <= '0;
      beta_q   <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      set_q    <= set_d;
      start_q  <= start_d;
      t_reg_q  <= t_reg_d;
      h_row_q  <= h_row_d;
      f_row_q  <= f_row_d;
      j_q      <= j_d;
      i_q      <= i_d;
      h_left_q <= h_left_d;
      e_left_q <= e_left_d;
      diag_q   <= diag_d;
      max_q    <= max_d;
      result_q <= result_d;
      match_q  <= match_d;
      mis_q    <= mis_d;
      alpha_q  <= alpha_d;
      beta_q   <= beta_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_fpga_wrapper.sv
// Bench for fpga_wrapper: five instances with different sequences share one stimulus
// stream and are compared every cycle against a matrix-level alignment model.
module tb_fpga_wrapper;

  localparam int NDUT = 5;
  localparam int TL_P[NDUT] = '{4, 4, 4, 4, 8};
  localparam int SL_P[NDUT] = '{4, 4, 4, 4, 8};
  localparam logic [15:0] TS_P[NDUT] = '{16'h00E4, 16'h00E4, 16'h00E4, 16'h00E4, 16'h9C4B};
  localparam logic [15:0] SS_P[NDUT] = '{16'h00E4, 16'h0038, 16'h00FF, 16'h00E4, 16'h2D7E};
  localparam int W_P[NDUT] = '{10, 10, 10, 4, 10};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       i_set_t = 1'b0;
  logic       i_start_cal = 1'b0;
  logic [3:0] i_match = '0;
  logic [3:0] i_mismatch = '0;
  logic [3:0] i_minus_alpha = '0;
  logic [3:0] i_minus_beta = '0;

  logic       busy_w [NDUT];
  logic       valid_w [NDUT];
  logic [9:0] result_w [NDUT];
  logic [3:0] res_d;
  assign result_w[3] = {6'b0, res_d};

  fpga_wrapper #(.T_LEN(4), .S_LEN(4), .T_SEQ(8'hE4), .S_SEQ(8'hE4), .SCORE_W(10)) u_a (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minus_alpha),
    .i_minusBeta(i_minus_beta), .o_busy(busy_w[0]), .o_valid(valid_w[0]), .o_result(result_w[0]));
  fpga_wrapper #(.T_LEN(4), .S_LEN(4), .T_SEQ(8'hE4), .S_SEQ(8'h38), .SCORE_W(10)) u_b (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minus_alpha),
    .i_minusBeta(i_minus_beta), .o_busy(busy_w[1]), .o_valid(valid_w[1]), .o_result(result_w[1]));
  fpga_wrapper #(.T_LEN(4), .S_LEN(4), .T_SEQ(8'hE4), .S_SEQ(8'hFF), .SCORE_W(10)) u_c (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minus_alpha),
    .i_minusBeta(i_minus_beta), .o_busy(busy_w[2]), .o_valid(valid_w[2]), .o_result(result_w[2]));
  fpga_wrapper #(.T_LEN(4), .S_LEN(4), .T_SEQ(8'hE4), .S_SEQ(8'hE4), .SCORE_W(4)) u_d (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minus_alpha),
    .i_minusBeta(i_minus_beta), .o_busy(busy_w[3]), .o_valid(valid_w[3]), .o_result(res_d));
  fpga_wrapper #(.T_LEN(8), .S_LEN(8), .T_SEQ(16'h9C4B), .S_SEQ(16'h2D7E), .SCORE_W(10)) u_e (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minus_alpha),
    .i_minusBeta(i_minus_beta), .o_busy(busy_w[4]), .o_valid(valid_w[4]), .o_result(result_w[4]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit init_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Full DP matrix straight from the recurrences; unsigned, saturating both ways.
  function automatic int sw_score(input int tl, input int sl, input logic [15:0] ts,
                                  input logic [15:0] ss, input int w, input int m,
                                  input int mm, input int a, input int b);
    int h[9][9];
    int e[9][9];
    int f[9][9];
    int best, maxv, sb, tb, d, x, y;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        h[r][c] = 0; e[r][c] = 0; f[r][c] = 0;
      end
    best = 0;
    maxv = (1 << w) - 1;
    for (int i = 1; i <= sl; i++) begin
      for (int j = 1; j <= tl; j++) begin
        sb = int'((ss >> (2 * (i - 1))) & 16'h3);
        tb = int'((ts >> (2 * (j - 1))) & 16'h3);
        x = (h[i][j-1] - a > 0) ? h[i][j-1] - a : 0;
        y = (e[i][j-1] - b > 0) ? e[i][j-1] - b : 0;
        e[i][j] = (x > y) ? x : y;
        x = (h[i-1][j] - a > 0) ? h[i-1][j] - a : 0;
        y = (f[i-1][j] - b > 0) ? f[i-1][j] - b : 0;
        f[i][j] = (x > y) ? x : y;
        if (sb == tb) d = (h[i-1][j-1] + m > maxv) ? maxv : h[i-1][j-1] + m;
        else          d = (h[i-1][j-1] - mm > 0) ? h[i-1][j-1] - mm : 0;
        h[i][j] = d;
        if (e[i][j] > h[i][j]) h[i][j] = e[i][j];
        if (f[i][j] > h[i][j]) h[i][j] = f[i][j];
        if (h[i][j] > best) best = h[i][j];
      end
    end
    return best;
  endfunction

  // Per instance: busy cycles still to show, captured command, load flag, results.
  int m_busy [NDUT];
  int m_pend [NDUT];
  int m_kind [NDUT];
  int m_loaded [NDUT];
  int m_result [NDUT];
  int m_res [NDUT];
  int m_pm [NDUT];
  int m_pmm [NDUT];
  int m_pa [NDUT];
  int m_pb [NDUT];
  bit m_valid [NDUT];
  int np_v;
  logic [9:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_pend[d] = 0; m_kind[d] = 0; m_loaded[d] = 0;
        m_result[d] = 0; m_valid[d] = 1'b0;
      end else begin
        np_v = 0;
        if (m_busy[d] == 0 && m_pend[d] == 0) begin
          if (i_set_t) np_v = 1;
          else if (i_start_cal) begin
            np_v = 2;
            m_pm[d] = int'(i_match); m_pmm[d] = int'(i_mismatch);
            m_pa[d] = int'(i_minus_alpha); m_pb[d] = int'(i_minus_beta);
          end
        end
        m_valid[d] = 1'b0;
        if (m_busy[d] > 0) begin
          m_busy[d]--;
          if (m_kind[d] == 2 && m_busy[d] == 1) begin
            m_valid[d] = 1'b1;
            m_result[d] = m_res[d];
          end
          if (m_kind[d] == 1 && m_busy[d] == 0) m_loaded[d] = 1;
        end else if (m_pend[d] == 1) begin
          m_busy[d] = TL_P[d];
          m_kind[d] = 1;
        end else if (m_pend[d] == 2 && m_loaded[d] != 0) begin
          m_busy[d] = TL_P[d] * SL_P[d] + 1;
          m_kind[d] = 2;
          m_res[d] = sw_score(TL_P[d], SL_P[d], TS_P[d], SS_P[d], W_P[d],
                              m_pm[d], m_pmm[d], m_pa[d], m_pb[d]);
          if (d == 4) exp_q.push_back(10'(m_res[d]));
        end
        m_pend[d] = np_v;
      end
    end
    if (rst) exp_q.delete();
  end

  // ---------------- compare / scoreboard ----------------
  int vcount [NDUT];
  int bcount [NDUT];
  int lastv [NDUT];

  always @(negedge clk) begin
    if (init_done) begin
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("busy[%0d]", d), int'(busy_w[d]), int'(m_busy[d] > 0));
        check($sformatf("valid[%0d]", d), int'(valid_w[d]), int'(m_valid[d]));
        check($sformatf("result[%0d]", d), int'(result_w[d]), m_result[d]);
        if (valid_w[d]) begin
          vcount[d]++;
          lastv[d] = cyc;
        end
        if (busy_w[d]) bcount[d]++;
      end
      if (valid_w[4]) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_result", int'(result_w[4]), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic set, input logic start, input int m, input int mm,
                           input int a, input int b, output int edge_no);
    @(negedge clk);
    i_set_t = set;
    i_start_cal = start;
    i_match = 4'(m);
    i_mismatch = 4'(mm);
    i_minus_alpha = 4'(a);
    i_minus_beta = 4'(b);
    edge_no = cyc + 1;
    @(negedge clk);
    i_set_t = 1'b0;
    i_start_cal = 1'b0;
  endtask

  task automatic wait_all_idle(input string name);
    int n;
    bit any;
    repeat (2) @(negedge clk);
    n = 0;
    while (1) begin
      any = 1'b0;
      for (int d = 0; d < NDUT; d++) any |= busy_w[d];
      if (!any) break;
      if (n >= 600) begin
        check({name, "_timeout"}, 1, 0);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int e_no, v0, b0, act;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    init_done = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_busy", int'(busy_w[0]), 0);
    check("reset_valid", int'(valid_w[0]), 0);
    check("reset_result", int'(result_w[0]), 0);

    v0 = vcount[0]; b0 = bcount[0];
    drive_cmd(1'b0, 1'b1, 2, 1, 3, 1, e_no);
    repeat (25) @(negedge clk);
    check("unloaded_start_valid", vcount[0] - v0, 0);
    check("unloaded_start_busy", bcount[0] - b0, 0);

    b0 = bcount[0];
    drive_cmd(1'b1, 1'b0, 0, 0, 0, 0, e_no);
    wait_all_idle("load");
    check("load_busy_cycles", bcount[0] - b0, 4);

    drive_cmd(1'b0, 1'b1, 2, 1, 3, 1, e_no);
    wait_all_idle("acgt");
    check("acgt_result", int'(result_w[0]), 8);
    check("acgt_latency", lastv[0] - e_no, 17);
    check("acgt_w4_result", int'(result_w[3]), 8);

    drive_cmd(1'b0, 1'b1, 0, 1, 3, 1, e_no);
    repeat (8) @(negedge clk);
    check("result_hold", int'(result_w[0]), 8);
    wait_all_idle("match0");
    check("match0_result", int'(result_w[0]), 0);

    drive_cmd(1'b0, 1'b1, 4, 4, 2, 1, e_no);
    wait_all_idle("agta");
    check("agta_gap_result", int'(result_w[1]), 10);

    drive_cmd(1'b0, 1'b1, 3, 2, 2, 1, e_no);
    wait_all_idle("tttt");
    check("tttt_result", int'(result_w[2]), 3);

    drive_cmd(1'b0, 1'b1, 15, 1, 3, 1, e_no);
    wait_all_idle("sat");
    check("sat_w4_result", int'(result_w[3]), 15);
    check("m15_w10_result", int'(result_w[0]), 60);

    v0 = vcount[0];
    drive_cmd(1'b0, 1'b1, 2, 1, 3, 1, e_no);
    repeat (5) @(negedge clk);
    drive_cmd(1'b0, 1'b1, 5, 5, 5, 5, e_no);
    wait_all_idle("dup_start");
    check("dup_start_strobes", vcount[0] - v0, 1);
    check("dup_start_result", int'(result_w[0]), 8);

    v0 = vcount[0]; b0 = bcount[0];
    drive_cmd(1'b1, 1'b1, 2, 1, 3, 1, e_no);
    wait_all_idle("both");
    check("both_busy_cycles", bcount[0] - b0, 4);
    check("both_no_valid", vcount[0] - v0, 0);

    v0 = vcount[0];
    drive_cmd(1'b0, 1'b1, 1, 1, 1, 1, e_no);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy_w[0]), 0);
    check("midrst_result", int'(result_w[0]), 0);
    check("midrst_busy_e", int'(busy_w[4]), 0);
    rst = 1'b0;
    check("midrst_no_valid", vcount[0] - v0, 0);
    b0 = bcount[0];
    drive_cmd(1'b0, 1'b1, 2, 1, 3, 1, e_no);
    repeat (30) @(negedge clk);
    check("post_rst_start_ignored", bcount[0] - b0, 0);
    drive_cmd(1'b1, 1'b0, 0, 0, 0, 0, e_no);
    wait_all_idle("reload");
    drive_cmd(1'b0, 1'b1, 2, 1, 3, 1, e_no);
    wait_all_idle("rerun");
    check("rerun_result", int'(result_w[0]), 8);

    for (int it = 0; it < 30; it++) begin
      act = int'($urandom_range(0, 11));
      if (act <= 1)
        drive_cmd(1'b1, 1'b0, 0, 0, 0, 0, e_no);
      else if (act <= 8)
        drive_cmd(1'b0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), e_no);
      else if (act <= 10)
        drive_cmd(1'b1, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), e_no);
      else
        pulse_reset();
      repeat ($urandom_range(0, 90)) @(negedge clk);
    end

    wait_all_idle("final");
    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
